// File: rtl/smag_mult_seq.sv
// Sequential shift-add sign-magnitude multiplier: one multiplier bit per clock,
// busy/done handshake toward an upstream sequencer.
module smag_mult_seq #(
    parameter int MAG_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [MAG_W:0]     number1_i,
    input  logic [MAG_W:0]     number2_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*MAG_W:0]   mult_o
);

    localparam int CNT_W = (MAG_W > 1) ? $clog2(MAG_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAG_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [MAG_W-1:0]   r_mcand;
    logic [MAG_W-1:0]   r_mplier;
    logic               r_sign;
    logic [2*MAG_W-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done;
    logic [2*MAG_W:0]   r_mult;
    logic [2*MAG_W-1:0] w_addend;
    logic               w_sign_out;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == CNT_LAST) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_addend   = {{MAG_W{1'b0}}, r_mcand} << r_cnt;
    // A zero magnitude is always reported as positive zero.
    assign w_sign_out = r_sign & (|r_acc);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_sign   <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_mult   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_mcand  <= number1_i[MAG_W-1:0];
                        r_mplier <= number2_i[MAG_W-1:0];
                        r_sign   <= number1_i[MAG_W] ^ number2_i[MAG_W];
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    if (r_mplier[0]) r_acc <= r_acc + w_addend;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                S_FIN: begin
                    r_mult <= {w_sign_out, r_acc};
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy_o = (r_state == S_RUN) || (r_state == S_FIN);
    assign done_o = r_done;
    assign mult_o = r_mult;

endmodule

// File: tb/tb_smag_mult_seq.sv
// Scoreboard bench for smag_mult_seq: expected products are queued at start
// and compared when done_o pulses.
module tb_smag_mult_seq;

    localparam int MAG_W = 4;
    localparam int LAT   = MAG_W + 1;  // negedge samples from start acceptance to done_o

    logic             clk;
    logic             rst;
    logic             start;
    logic [MAG_W:0]   num1;
    logic [MAG_W:0]   num2;
    logic             busy;
    logic             done;
    logic [2*MAG_W:0] mult;

    logic [2*MAG_W:0] sb_q[$];
    logic [2*MAG_W:0] last_mult;
    int               n_vec;
    int               n_err;

    smag_mult_seq #(.MAG_W(MAG_W)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .number1_i (num1),
        .number2_i (num2),
        .busy_o    (busy),
        .done_o    (done),
        .mult_o    (mult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*MAG_W:0] model(input logic [MAG_W:0] a, input logic [MAG_W:0] b);
        logic [2*MAG_W-1:0] mag;
        logic               sgn;
        mag = (2*MAG_W)'(a[MAG_W-1:0]) * (2*MAG_W)'(b[MAG_W-1:0]);
        sgn = (a[MAG_W] ^ b[MAG_W]) && (mag != '0);
        return {sgn, mag};
    endfunction

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic do_start(input logic [MAG_W:0] a, input logic [MAG_W:0] b);
        start = 1'b1;
        num1  = a;
        num2  = b;
        sb_q.push_back(model(a, b));
        @(negedge clk);
        start = 1'b0;
        num1  = $urandom_range(0, 31);
        num2  = $urandom_range(0, 31);
    endtask

    task automatic wait_done(input int exp_lat, input string tag);
        int k;
        logic [2*MAG_W:0] exp_v;
        k = 0;
        while (done !== 1'b1 && k < 20) begin
            n_vec++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL %s busy: got %b want 1 at sample %0d", tag, busy, k);
            end
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (k !== exp_lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d want %0d", tag, k, exp_lat);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s busy_in_done: got %b want 0", tag, busy);
        end
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL %s scoreboard: got result %b want none pending", tag, mult);
        end else begin
            exp_v = sb_q.pop_front();
            n_vec++;
            if (mult !== exp_v) begin
                n_err++;
                $display("FAIL %s mult: got %b want %b", tag, mult, exp_v);
            end
        end
        last_mult = mult;
    endtask

    task automatic check_hold(input string tag);
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0 || mult !== last_mult) begin
            n_err++;
            $display("FAIL %s hold: got done=%b mult=%b want done=0 mult=%b", tag, done, mult, last_mult);
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b1;  // reset must win over start
        num1  = 5'b00110;
        num2  = 5'b00011;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (mult !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset: got mult=%b busy=%b done=%b want 0/0/0", mult, busy, done);
        end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_basic;
        do_start(5'b00110, 5'b10011);
        wait_done(LAT, "basic");
        check_hold("basic");
    endtask

    task automatic test_back_to_back;
        do_start(5'b01110, 5'b10011);
        wait_done(LAT, "b2b0");
        do_start(5'b10001, 5'b00010);
        wait_done(LAT, "b2b1");
        do_start(5'b10110, 5'b00110);
        wait_done(LAT, "b2b2");
        check_hold("b2b");
    endtask

    task automatic test_boundaries;
        do_start(5'b01111, 5'b11111);
        wait_done(LAT, "max");
        check_hold("max");
        do_start(5'b10000, 5'b00101);
        wait_done(LAT, "negzero");
        check_hold("negzero");
        do_start(5'b10000, 5'b10000);
        wait_done(LAT, "zero");
        check_hold("zero");
    endtask

    task automatic test_start_while_busy;
        do_start(5'b00101, 5'b00111);
        @(negedge clk);
        start = 1'b1;
        num1  = 5'b11111;
        num2  = 5'b11111;
        @(negedge clk);
        start = 1'b0;
        wait_done(LAT - 2, "busy_start");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL busy_start_extra: got done=%b busy=%b want 0/0 at %0d", done, busy, i);
            end
        end
    endtask

    task automatic test_reset_midop;
        do_start(5'b01110, 5'b00011);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb_q.pop_back());
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || mult !== '0) begin
            n_err++;
            $display("FAIL reset_mid: got busy=%b done=%b mult=%b want 0/0/0", busy, done, mult);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_vec++;
            if (done !== 1'b0) begin
                n_err++;
                $display("FAIL reset_mid_done: got done=%b want 0 at %0d", done, i);
            end
        end
        do_start(5'b00011, 5'b00011);
        wait_done(LAT, "after_reset");
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        start     = 1'b0;
        num1      = '0;
        num2      = '0;
        last_mult = '0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_back_to_back;
        test_boundaries;
        test_start_while_busy;
        test_reset_midop;
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: got %0d pending want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
